// File: rtl/factorial_accel_slave_if.sv
// Slave-bus signal bundle for the factorial accelerator.
// The master drives select/write/address/data; the slave returns registered read data.
interface factorial_accel_slave_if;
  logic        S_sel;
  logic        S_wr;
  logic [7:0]  S_address;
  logic [31:0] S_din;
  logic [31:0] S_dout;

  modport master (output S_sel, output S_wr, output S_address, output S_din, input S_dout);
  modport slave  (input S_sel, input S_wr, input S_address, input S_din, output S_dout);
endinterface

// File: rtl/factorial_accel_slave.sv
// Register-mapped factorial accelerator: bus register file plus an iterative
// multiply engine that computes N! one multiply per cycle.
//
// state | meaning
// IDLE  | waiting for OP_START; N_VALUE writable
// EXEC  | multiplying acc by cnt, cnt counting down to 1
// DONE  | result held until OP_CLEAR
module factorial_accel_slave #(
  parameter int N_WIDTH      = 8,
  parameter int RESULT_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  factorial_accel_slave_if.slave  bus,
  output logic                    f_interrupt
);

  localparam int RESULT_WORDS = RESULT_WIDTH / 32;
  localparam int PROD_WIDTH   = RESULT_WIDTH + N_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t                  state_q, state_d;
  logic [N_WIDTH-1:0]      n_value_q, n_value_d;
  logic                    intr_en_q, intr_en_d;
  logic [RESULT_WIDTH-1:0] acc_q, acc_d;
  logic [N_WIDTH-1:0]      cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic [31:0]             dout_q, dout_d;

  logic [4:0]              addr;
  logic                    wr_en, rd_en;
  logic                    start_req, clear_req;
  logic [PROD_WIDTH-1:0]   prod;
  logic [31:0]             rdata;
  logic                    unused_bits;

  assign addr      = bus.S_address[4:0];
  assign wr_en     = bus.S_sel & bus.S_wr;
  assign rd_en     = bus.S_sel & ~bus.S_wr;
  assign start_req = wr_en && (addr == 5'h03) && bus.S_din[0];
  assign clear_req = wr_en && (addr == 5'h04) && bus.S_din[0];
  assign unused_bits = ^{bus.S_address[7:5], bus.S_din};

  assign prod = PROD_WIDTH'(acc_q) * PROD_WIDTH'(cnt_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      n_value_q <= '0;
      intr_en_q <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      n_value_q <= n_value_d;
      intr_en_q <= intr_en_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      dout_q    <= dout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    n_value_d = n_value_q;
    intr_en_d = intr_en_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;

    if (wr_en && (addr == 5'h00) && (state_q == ST_IDLE)) n_value_d = bus.S_din[N_WIDTH-1:0];
    if (wr_en && (addr == 5'h01)) intr_en_d = bus.S_din[0];

    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          acc_d   = RESULT_WIDTH'(1);
          cnt_d   = n_value_q;
          ovf_d   = 1'b0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q <= N_WIDTH'(1)) begin
          state_d = ST_DONE;
        end else begin
          acc_d = prod[RESULT_WIDTH-1:0];
          cnt_d = cnt_q - N_WIDTH'(1);
          if (|prod[PROD_WIDTH-1:RESULT_WIDTH]) ovf_d = 1'b1;
        end
      end
      default: ;
    endcase

    // Clear wins over whatever the engine would have done this cycle.
    if (clear_req) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      5'h00: rdata[N_WIDTH-1:0] = n_value_q;
      5'h01: rdata[0] = intr_en_q;
      5'h02: rdata[3:0] = {state_q == ST_DONE, ovf_q, state_q};
      default: begin
        if (addr[4:3] == 2'b01) begin
          for (int i = 0; i < RESULT_WORDS; i++) begin
            if (addr[2:0] == 3'(i)) rdata = acc_q[32*i +: 32];
          end
        end
      end
    endcase
    dout_d = rd_en ? rdata : '0;
  end

  assign bus.S_dout  = dout_q;
  assign f_interrupt = (state_q == ST_DONE) & intr_en_q;

endmodule

// File: tb/tb_factorial_accel_slave.sv
// Self-checking bench: a 64-bit and a 32-bit result instance share identical
// bus stimulus and are compared against a plain-arithmetic factorial model.
module tb_factorial_accel_slave;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  factorial_accel_slave_if b64();
  factorial_accel_slave_if b32();
  logic f64, f32;

  factorial_accel_slave #(.N_WIDTH(8), .RESULT_WIDTH(64)) dut64 (
    .clk(clk), .reset_n(reset_n), .bus(b64.slave), .f_interrupt(f64));
  factorial_accel_slave #(.N_WIDTH(8), .RESULT_WIDTH(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .bus(b32.slave), .f_interrupt(f32));

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          w;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] e;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit w, input logic [7:0] a, input logic [31:0] d);
    b64.S_sel = sel; b64.S_wr = w; b64.S_address = a; b64.S_din = d;
    b32.S_sel = sel; b32.S_wr = w; b32.S_address = a; b32.S_din = d;
  endtask

  // Called at a negedge; applies inputs across one rising edge and returns at the next negedge.
  task automatic step(input bit sel, input bit w, input logic [7:0] a, input logic [31:0] d);
    drive(sel, w, a, d);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] r64, output logic [31:0] r32);
    step(1'b1, 1'b0, a, 32'h0);
    r64 = b64.S_dout;
    r32 = b32.S_dout;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  // Reference: N! as an ascending product, truncated to w bits; overflow once any partial exceeds w bits.
  function automatic void model(input int n, input int w, output logic [63:0] acc, output bit ovf);
    logic [127:0] full;
    acc = 64'd1;
    ovf = 1'b0;
    for (int k = 2; k <= n; k++) begin
      full = {64'd0, acc} * 128'(k);
      if ((full >> w) != 128'd0) ovf = 1'b1;
      acc = (w == 64) ? full[63:0] : {32'd0, full[31:0]};
    end
  endfunction

  task automatic poll_done(input string name, input int exp_reads);
    logic [31:0] s64, s32;
    int cyc = 0;
    bit done = 1'b0;
    while (!done && cyc < 300) begin
      rd(8'h02, s64, s32);
      cyc++;
      if (s64[3]) done = 1'b1;
    end
    chk({name, "_latency"}, 32'(cyc), 32'(exp_reads));
  endtask

  task automatic run_and_check(input int n, input bit ie, input string name,
                               output logic [31:0] r0_64, output logic [31:0] r1_64,
                               output logic [31:0] r0_32, output logic [31:0] st32);
    logic [31:0] s64, s32, x;
    logic [63:0] e64, e32;
    bit o64, o32;
    wr(8'h04, 32'h1);
    wr(8'h00, 32'(n));
    wr(8'h01, {31'd0, ie});
    wr(8'h03, 32'h1);
    poll_done(name, ((n < 1) ? 1 : n) + 1);
    model(n, 64, e64, o64);
    model(n, 32, e32, o32);
    rd(8'h02, s64, s32);
    chk({name, "_status64"}, s64, 32'h0000000A | (32'(o64) << 2));
    chk({name, "_status32"}, s32, 32'h0000000A | (32'(o32) << 2));
    chk({name, "_irq64"}, {31'd0, f64}, {31'd0, ie});
    chk({name, "_irq32"}, {31'd0, f32}, {31'd0, ie});
    rd(8'h08, r0_64, r0_32);
    chk({name, "_res0_64"}, r0_64, e64[31:0]);
    chk({name, "_res0_32"}, r0_32, e32[31:0]);
    rd(8'h09, r1_64, x);
    chk({name, "_res1_64"}, r1_64, e64[63:32]);
    chk({name, "_res1_32"}, x, 32'h0);
    st32 = s32;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[$];
    logic [31:0] a64, a32, r0, r1, q0, st;
    bit seen;

    drive(1'b0, 1'b0, 8'h00, 32'h0);
    reset_n = 1'b0;
    @(negedge clk);
    idle(); idle();
    reset_n = 1'b1;
    chk("reset_irq64", {31'd0, f64}, 32'h0);
    chk("reset_irq32", {31'd0, f32}, 32'h0);
    chk("reset_dout", b64.S_dout, 32'h0);

    for (int i = 0; i < 16; i++) vt.push_back('{1'b0, 8'(i), 32'h0, 32'h0});
    vt.push_back('{1'b1, 8'h20, 32'h00000005, 32'h0});
    vt.push_back('{1'b0, 8'h00, 32'h0, 32'h00000005});
    vt.push_back('{1'b1, 8'h00, 32'hFFFFFF37, 32'h0});
    vt.push_back('{1'b0, 8'hE0, 32'h0, 32'h00000037});
    vt.push_back('{1'b1, 8'h01, 32'hFFFFFFFE, 32'h0});
    vt.push_back('{1'b0, 8'h01, 32'h0, 32'h0});
    vt.push_back('{1'b1, 8'h41, 32'h00000001, 32'h0});
    vt.push_back('{1'b0, 8'h01, 32'h0, 32'h00000001});
    vt.push_back('{1'b1, 8'h1F, 32'h0000FFFF, 32'h0});
    vt.push_back('{1'b0, 8'h1F, 32'h0, 32'h0});
    vt.push_back('{1'b1, 8'h02, 32'h0000000F, 32'h0});
    vt.push_back('{1'b0, 8'h02, 32'h0, 32'h0});
    vt.push_back('{1'b0, 8'h03, 32'h0, 32'h0});
    vt.push_back('{1'b0, 8'h04, 32'h0, 32'h0});
    foreach (vt[i]) begin
      if (vt[i].w) wr(vt[i].a, vt[i].d);
      else begin
        rd(vt[i].a, a64, a32);
        chk($sformatf("vec%0d_a%02h_64", i, vt[i].a), a64, vt[i].e);
        chk($sformatf("vec%0d_a%02h_32", i, vt[i].a), a32, vt[i].e);
      end
    end
    idle();
    chk("dout_one_cycle", b64.S_dout, 32'h0);

    // N=5 with per-cycle status and interrupt timing
    wr(8'h04, 32'h1);
    wr(8'h00, 32'd5);
    wr(8'h01, 32'h1);
    wr(8'h03, 32'h1);
    for (int i = 1; i <= 6; i++) begin
      rd(8'h02, a64, a32);
      chk($sformatf("n5_status_c%0d", i), a64, (i <= 5) ? 32'h1 : 32'hA);
      chk($sformatf("n5_irq_c%0d", i), {31'd0, f64}, (i >= 5) ? 32'h1 : 32'h0);
    end
    rd(8'h08, a64, a32);
    chk("n5_res0", a64, 32'h78);
    chk("n5_res0_32", a32, 32'h78);
    rd(8'h09, a64, a32);
    chk("n5_res1", a64, 32'h0);

    run_and_check(20, 1'b1, "n20", r0, r1, q0, st);
    chk("n20_lo", r0, 32'h82B40000);
    chk("n20_hi", r1, 32'h21C3677C);
    run_and_check(21, 1'b0, "n21", r0, r1, q0, st);
    run_and_check(0, 1'b1, "n0", r0, r1, q0, st);
    chk("n0_one", r0, 32'h1);
    run_and_check(1, 1'b0, "n1", r0, r1, q0, st);
    chk("n1_one", r0, 32'h1);
    run_and_check(12, 1'b1, "n12", r0, r1, q0, st);
    chk("n12_w32", q0, 32'h1C8CFC00);
    run_and_check(13, 1'b1, "n13", r0, r1, q0, st);
    chk("n13_w32_status", st, 32'hE);
    for (int i = 0; i < 8; i++) begin
      int n;
      n = (i == 7) ? int'($urandom_range(100, 255)) : int'($urandom_range(0, 40));
      run_and_check(n, 1'($urandom_range(0, 1)), $sformatf("rnd%0d_n%0d", i, n), r0, r1, q0, st);
    end

    // intr_en set while already DONE, then cleared by OP_CLEAR
    run_and_check(3, 1'b0, "n3", r0, r1, q0, st);
    wr(8'h01, 32'h1);
    chk("late_irq64", {31'd0, f64}, 32'h1);
    chk("late_irq32", {31'd0, f32}, 32'h1);
    wr(8'h04, 32'h1);
    chk("clear_irq", {31'd0, f64}, 32'h0);
    rd(8'h08, a64, a32);
    chk("clear_acc", a64, 32'h0);

    // start with S_sel low does nothing
    step(1'b0, 1'b1, 8'h03, 32'h1);
    rd(8'h02, a64, a32);
    chk("nosel_status", a64, 32'h0);

    // N_VALUE write and second start during EXEC are ignored
    wr(8'h00, 32'd10);
    wr(8'h03, 32'h1);
    wr(8'h00, 32'd3);
    wr(8'h03, 32'h1);
    poll_done("exec_ignore", 9);
    rd(8'h08, a64, a32);
    chk("exec_ignore_res", a64, 32'h00375F00);
    rd(8'h00, a64, a32);
    chk("exec_ignore_n", a64, 32'd10);

    // back-to-back: start the cycle after clear
    wr(8'h04, 32'h1);
    wr(8'h03, 32'h1);
    rd(8'h02, a64, a32);
    chk("b2b_status", a64, 32'h1);

    // OP_CLEAR mid-EXEC: never interrupts
    idle();
    wr(8'h04, 32'h1);
    chk("midclr_irq", {31'd0, f64}, 32'h0);
    rd(8'h02, a64, a32);
    chk("midclr_status", a64, 32'h0);
    rd(8'h08, a64, a32);
    chk("midclr_acc", a64, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      idle();
      if (f64 || f32) seen = 1'b1;
    end
    chk("midclr_irq_quiet", {31'd0, seen}, 32'h0);

    // reset mid-EXEC
    wr(8'h03, 32'h1);
    idle(); idle();
    reset_n = 1'b0;
    step(1'b1, 1'b0, 8'h08, 32'h0);
    reset_n = 1'b1;
    chk("rst_dout", b64.S_dout, 32'h0);
    chk("rst_irq", {31'd0, f64}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] ra;
      ra = (i == 3) ? 8'h08 : 8'(i);
      rd(ra, a64, a32);
      chk($sformatf("rst_reg%02h", ra), a64, 32'h0);
    end
    wr(8'h03, 32'h1);
    rd(8'h02, a64, a32);
    chk("rst_n0_exec", a64, 32'h1);
    rd(8'h02, a64, a32);
    chk("rst_n0_done", a64, 32'hA);
    rd(8'h08, a64, a32);
    chk("rst_n0_res", a64, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/factorial_accel_slave.md
# factorial_accel_slave

Register-mapped factorial accelerator for the on-chip slave bus. It combines the bus-slave register file with an iterative multiply engine, parametrised in operand and result width. It adds the following over the previous generation:
- honours `S_sel`
- allows reads in every state
- reports a sticky overflow flag
- exposes the result as a variable number of 32-bit words

It sits on the slave port of the bus and raises `f_interrupt` toward the interrupt controller.

## Interface
- `N_WIDTH`, default 8: significant bits of N; legal range 1..32.
- `RESULT_WIDTH`, default 64: accumulator width; must be a multiple of 32, legal range 32..256.
- `RESULT_WORDS` (derived, not overridable) = `RESULT_WIDTH/32`.
- `clk` in 1: single clock; all logic on its rising edge.
- `reset_n` in 1: reset is synchronous and active-low.
- `S_sel` in 1: slave select; access happens only when 1.
- `S_wr` in 1: 1 = write, 0 = read.
- `S_address` in 8: register address; only `[4:0]` decoded, so upper bits alias.
- `S_din` in 32: write data.
- `S_dout` out 32: registered read data.
- `f_interrupt` out 1: level interrupt = (state==DONE) & intr_en.

## Operation
Register map (word addresses on `S_address[4:0]`):
- 0x00 N_VALUE (RW): bits `[N_WIDTH-1:0]` stored; upper bits read 0. Writes are ignored unless state==IDLE.
- 0x01 INTR_EN (RW): bit0. Writable in any state.
- 0x02 STATUS (RO):
  - `[1:0]` state: IDLE=00, EXEC=01, DONE=10.
  - bit2 overflow.
  - bit3 done (= state==DONE).
  - other bits 0.
- 0x03 OP_START (WO): writing bit0=1 in IDLE starts an operation. Ignored in EXEC/DONE. Reads 0.
- 0x04 OP_CLEAR (WO): writing bit0=1 in any state forces IDLE, sets acc=0 and clears overflow. N_VALUE and INTR_EN are kept. Reads 0.
- 0x08+i RESULT[i] (RO), i in 0..RESULT_WORDS-1: `acc[32i+31:32i]`. Readable in any state; mid-EXEC reads return the partial product.
- Any unmapped address: reads 0; writes ignored.

Engine (cnt is N_WIDTH bits, acc is RESULT_WIDTH bits):
- Start in IDLE → acc<=1, cnt<=N_VALUE, overflow<=0, state<=EXEC.
- EXEC, cnt<=1 → state<=DONE; acc and cnt unchanged.
- EXEC, cnt>1 → acc<=(acc*cnt) truncated to RESULT_WIDTH; cnt<=cnt-1. If the full product has any nonzero bit at or above RESULT_WIDTH, overflow<=1 (sticky).
- DONE is held until OP_CLEAR; state then goes to IDLE. acc stays at 0 until the next start.
- One multiply per cycle; the multiplier is combinational, RESULT_WIDTH × N_WIDTH.
- 0! = 1! = 1.

Bus rules:
- A write occurs only on a cycle with S_sel=1 and S_wr=1.
- A read is S_sel=1 and S_wr=0. `S_dout` is loaded on that edge with the value of the addressed register before that edge's updates.
- Whenever no read occurs, `S_dout` is loaded with 0.
- The OP_CLEAR bus write takes priority over the engine update in the same cycle.

Reset (reset_n=0 at a rising edge) applies the following values. Reset mid-EXEC aborts with no residue.
- state=IDLE
- N_VALUE=0
- intr_en=0
- acc=0
- cnt=0
- overflow=0
- `S_dout`=0
- `f_interrupt`=0

## Timing
- Write takes effect at the edge where it is sampled; the register is visible on the following cycle.
- Read latency is 1 cycle: address at edge t, data on `S_dout` after t, valid for one cycle only.
- Start written at edge t0: state=EXEC after t0. DONE is visible after edge t0+max(N,1).
  - N≥2 takes N−1 multiply cycles plus 1 terminating cycle.
- `f_interrupt` asserts in the same cycle the state becomes DONE, provided intr_en=1.
  - Setting intr_en while already in DONE asserts it on the next cycle.
  - It deasserts the cycle after an OP_CLEAR write.
- Back-to-back operation: start is accepted the cycle after OP_CLEAR returns state to IDLE.

## Test plan
- Reset, then read each address 0x00–0x0F → all read 0; `f_interrupt`=0.
- N=5, INTR_EN=1, start → STATUS=0x1 for cycles 1..4, DONE after 5 cycles; `f_interrupt`=1; RESULT[0]=0x78, RESULT[1]=0; STATUS=0xA.
- Default widths, N=20 → RESULT[1]:RESULT[0]=0x21C3677C_82B40000, overflow=0. Then clear and run N=21 → overflow=1, STATUS=0xE, result truncated mod 2^64.
- N=0 and N=1 → DONE 1 cycle after start, RESULT[0]=1.
- Start with S_sel=0 → no change. Write N_VALUE and a second start during EXEC → both ignored, result unchanged. OP_CLEAR mid-EXEC → IDLE next cycle, acc=0, `f_interrupt` never asserts.
- Assert reset_n=0 for 1 cycle mid-EXEC (N=10) → all registers at reset values next cycle. Re-run with RESULT_WIDTH=32, N=13 → overflow=1 (13! > 2^32), 12! = 0x1C8CFC00 with no overflow.
